usart_link: RTL

USART_LINK -- requirements
Module: usart_link

---
 rtl/usart_pkg.sv | 21 ++
 rtl/usart_bit_timer.sv | 46 ++++
 rtl/usart_link.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/usart_pkg.sv
// ---------------------------------------------------------------------------
// usart_pkg : FSM state encoding and line constants shared by the USART link
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package usart_pkg;

   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } usart_state_e;

endpackage

`default_nettype wire

// File: rtl/usart_bit_timer.sv
// ---------------------------------------------------------------------------
// usart_bit_timer : counts 0..CLKS_PER_BIT-1 per serial bit, mid/end strobes
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic restart_i,
   output logic mid_o,
   output logic end_o
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Restart wins over enable so a new bit period can begin from an idle cycle.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (restart_i || !en_i || (cnt_q == END_CNT)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign mid_o = en_i && (cnt_q == MID_CNT);
   assign end_o = en_i && (cnt_q == END_CNT);

endmodule

`default_nettype wire

// File: rtl/usart_link.sv
// ---------------------------------------------------------------------------
// usart_link : independent UART-style serial transmitter and receiver.
//              Optional even parity bit when USART_LINK_PARITY_EN is defined.
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usart_link
   import usart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int MSB_FIRST    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_din,
   output logic              tx_ready,
   output logic              tx_data,
   input  logic              rx_data,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_dout,
   output logic              rx_frame_err,
   output logic              rx_parity_err
);

   localparam int               IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
`ifdef USART_LINK_PARITY_EN
   localparam usart_state_e     ST_AFTER_DATA = ST_PARITY;
`else
   localparam usart_state_e     ST_AFTER_DATA = ST_STOP;
`endif

   // ---------------- transmitter ----------------
   usart_state_e      tx_state_q, tx_state_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [IDX_W-1:0]  tx_idx_q, tx_idx_d;
   logic              tx_accept;
   logic              tx_mid_unused;
   logic              tx_end;

   assign tx_ready  = (tx_state_q == ST_IDLE);
   assign tx_accept = tx_valid && tx_ready;

   usart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
      .clk       (clk),
      .reset     (reset),
      .en_i      (tx_state_q != ST_IDLE),
      .restart_i (tx_accept),
      .mid_o     (tx_mid_unused),
      .end_o     (tx_end)
   );

   always_comb begin
      tx_state_d = tx_state_q;
      tx_shift_d = tx_shift_q;
      tx_idx_d   = tx_idx_q;
      case (tx_state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               tx_state_d = ST_START;
               tx_shift_d = tx_din;
               tx_idx_d   = '0;
            end
         end
         ST_START: if (tx_end) tx_state_d = ST_DATA;
         ST_DATA: begin
            if (tx_end) begin
               if (tx_idx_q == LAST_IDX) begin
                  tx_state_d = ST_AFTER_DATA;
               end else begin
                  tx_idx_d   = tx_idx_q + 1'b1;
                  tx_shift_d = (MSB_FIRST != 0) ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                                : {1'b0, tx_shift_q[DATA_W-1:1]};
               end
            end
         end
`ifdef USART_LINK_PARITY_EN
         ST_PARITY: if (tx_end) tx_state_d = ST_STOP;
`endif
         ST_STOP: if (tx_end) tx_state_d = ST_IDLE;
         default: tx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_shift_q <= '0;
         tx_idx_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_shift_q <= tx_shift_d;
         tx_idx_q   <= tx_idx_d;
      end
   end

`ifdef USART_LINK_PARITY_EN
   logic tx_par_q;

   // Parity is captured at acceptance so later tx_din changes cannot leak in.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_par_q <= 1'b0;
      end else if (tx_accept) begin
         tx_par_q <= ^tx_din;
      end
   end
`endif

   always_comb begin
      tx_data = IDLE_LEVEL;
      case (tx_state_q)
         ST_START:  tx_data = 1'b0;
         ST_DATA:   tx_data = (MSB_FIRST != 0) ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
`ifdef USART_LINK_PARITY_EN
         ST_PARITY: tx_data = tx_par_q;
`endif
         default:   tx_data = IDLE_LEVEL;
      endcase
   end

   // ---------------- receiver ----------------
   logic              rx_sync1_q, rx_sync2_q, rx_prev_q;
   usart_state_e      rx_state_q, rx_state_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
   logic [DATA_W-1:0] rx_dout_q, rx_dout_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_ferr_q, rx_ferr_d;
   logic              rx_fall;
   logic              rx_mid;
   logic              rx_end;
`ifdef USART_LINK_PARITY_EN
   logic              rx_par_q, rx_par_d;
   logic              rx_perr_q, rx_perr_d;
`endif

   assign rx_fall = (rx_state_q == ST_IDLE) && rx_prev_q && !rx_sync2_q;

   usart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
      .clk       (clk),
      .reset     (reset),
      .en_i      (rx_state_q != ST_IDLE),
      .restart_i (rx_fall),
      .mid_o     (rx_mid),
      .end_o     (rx_end)
   );

   always_comb begin
      rx_state_d = rx_state_q;
      rx_shift_d = rx_shift_q;
      rx_idx_d   = rx_idx_q;
      rx_dout_d  = rx_dout_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
`ifdef USART_LINK_PARITY_EN
      rx_par_d   = rx_par_q;
      rx_perr_d  = 1'b0;
`endif
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               rx_state_d = ST_START;
               rx_idx_d   = '0;
            end
         end
         ST_START: begin
            if (rx_mid && rx_sync2_q) begin
               rx_state_d = ST_IDLE;
            end else if (rx_end) begin
               rx_state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rx_mid) begin
               rx_shift_d = (MSB_FIRST != 0) ? {rx_shift_q[DATA_W-2:0], rx_sync2_q}
                                             : {rx_sync2_q, rx_shift_q[DATA_W-1:1]};
            end
            if (rx_end) begin
               if (rx_idx_q == LAST_IDX) begin
                  rx_state_d = ST_AFTER_DATA;
               end else begin
                  rx_idx_d = rx_idx_q + 1'b1;
               end
            end
         end
`ifdef USART_LINK_PARITY_EN
         ST_PARITY: begin
            if (rx_mid) rx_par_d = rx_sync2_q;
            if (rx_end) rx_state_d = ST_STOP;
         end
`endif
         // Leave at the stop mid-point so the next start edge is never missed.
         ST_STOP: begin
            if (rx_mid) begin
               rx_state_d = ST_IDLE;
               rx_dout_d  = rx_shift_q;
               rx_valid_d = 1'b1;
               rx_ferr_d  = !rx_sync2_q;
`ifdef USART_LINK_PARITY_EN
               rx_perr_d  = (rx_par_q != ^rx_shift_q);
`endif
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync1_q <= IDLE_LEVEL;
         rx_sync2_q <= IDLE_LEVEL;
         rx_prev_q  <= IDLE_LEVEL;
         rx_state_q <= ST_IDLE;
         rx_shift_q <= '0;
         rx_idx_q   <= '0;
         rx_dout_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_sync1_q <= rx_data;
         rx_sync2_q <= rx_sync1_q;
         rx_prev_q  <= rx_sync2_q;
         rx_state_q <= rx_state_d;
         rx_shift_q <= rx_shift_d;
         rx_idx_q   <= rx_idx_d;
         rx_dout_q  <= rx_dout_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

`ifdef USART_LINK_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_par_q  <= 1'b0;
         rx_perr_q <= 1'b0;
      end else begin
         rx_par_q  <= rx_par_d;
         rx_perr_q <= rx_perr_d;
      end
   end
   assign rx_parity_err = rx_perr_q;
`else
   assign rx_parity_err = 1'b0;
`endif

   assign rx_valid     = rx_valid_q;
   assign rx_dout      = rx_dout_q;
   assign rx_frame_err = rx_ferr_q;

endmodule

`default_nettype wire
